// File: rtl/macc_arbiter.sv
// Round-robin, frame-granular arbiter sharing one Macc2 between NCH A/B stream pairs.
// Results return in frame order and carry the producing channel's ID from a tag FIFO.
module macc_arbiter #(
  parameter  int unsigned NCH       = 4,
  parameter  int unsigned ADW       = 24,
  parameter  int unsigned BDW       = 18,
  parameter  int unsigned ODW       = 48,
  parameter  int unsigned TAG_DEPTH = 4,
  localparam int unsigned IDW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*ADW-1:0]   s_axis_atdata,
  input  logic [NCH-1:0]       s_axis_atvalid,
  output logic [NCH-1:0]       s_axis_atready,
  input  logic [NCH-1:0]       s_axis_atlast,
  input  logic [NCH*BDW-1:0]   s_axis_btdata,
  input  logic [NCH-1:0]       s_axis_btvalid,
  output logic [NCH-1:0]       s_axis_btready,
  output logic [ADW-1:0]       m_macc_atdata,
  output logic                 m_macc_atvalid,
  input  logic                 m_macc_atready,
  output logic                 m_macc_atlast,
  output logic [BDW-1:0]       m_macc_btdata,
  output logic                 m_macc_btvalid,
  input  logic                 m_macc_btready,
  input  logic [ODW-1:0]       s_macc_tdata,
  input  logic                 s_macc_tvalid,
  output logic                 s_macc_tready,
  output logic [ODW-1:0]       m_axis_tdata,
  output logic [IDW-1:0]       m_axis_tid,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready
);

  localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_grant;
  logic [IDW-1:0]  w_grant_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  w_rr_ptr_nxt;
  logic [IDW-1:0]  w_winner;
  logic            w_found;
  logic            w_frame_end;
  logic            w_push;
  logic            w_pop;

  logic [IDW-1:0]  r_tag_mem [TAG_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [ADW-1:0]  w_adata [NCH];
  logic [BDW-1:0]  w_bdata [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_unpack
    assign w_adata[g] = s_axis_atdata[g*ADW +: ADW];
    assign w_bdata[g] = s_axis_btdata[g*BDW +: BDW];
  end

  // First requester strictly after rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      automatic int unsigned idx;
      idx = (32'(r_rr_ptr) + k) % NCH;
      if (!w_found && s_axis_atvalid[IDW'(idx)]) begin
        w_found  = 1'b1;
        w_winner = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= IDW'(NCH - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_frame_end    = 1'b0;
    m_macc_atdata  = '0;
    m_macc_atvalid = 1'b0;
    m_macc_atlast  = 1'b0;
    m_macc_btdata  = '0;
    m_macc_btvalid = 1'b0;
    s_axis_atready = '0;
    s_axis_btready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && (r_count < CW'(TAG_DEPTH))) begin
          w_grant_nxt = w_winner;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        m_macc_atdata           = w_adata[r_grant];
        m_macc_atvalid          = s_axis_atvalid[r_grant];
        m_macc_atlast           = s_axis_atlast[r_grant];
        m_macc_btdata           = w_bdata[r_grant];
        m_macc_btvalid          = s_axis_btvalid[r_grant];
        s_axis_atready[r_grant] = m_macc_atready;
        s_axis_btready[r_grant] = m_macc_btready;
        w_frame_end = s_axis_atvalid[r_grant] && m_macc_atready && s_axis_atlast[r_grant];
        if (w_frame_end) begin
          w_rr_ptr_nxt = r_grant;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result path is a straight pass-through; only the ID comes from the tag FIFO.
  assign m_axis_tdata  = s_macc_tdata;
  assign m_axis_tvalid = s_macc_tvalid;
  assign s_macc_tready = m_axis_tready;
  assign m_axis_tid    = r_tag_mem[r_rd_ptr];

  assign w_push = w_frame_end;
  assign w_pop  = s_macc_tvalid && m_axis_tready && (r_count != '0);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == TAG_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag_mem[r_wr_ptr] <= r_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_result_has_tag: assert property (@(posedge clk) disable iff (rst)
    !(s_macc_tvalid && (r_count == '0)))
    else $error("macc_arbiter: Macc2 result with empty tag FIFO");
`endif

endmodule

// File: tb/tb_macc_arbiter.sv
// Bench for macc_arbiter: per-channel beat queues, a behavioural Macc2, table vectors
// and directed multi-cycle sequences.
module tb_macc_arbiter;
  localparam int unsigned NCH = 4, ADW = 24, BDW = 18, ODW = 48, TAG_DEPTH = 4;
  localparam int unsigned IDW = 2, DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NCH*ADW-1:0] s_axis_atdata;
  logic [NCH-1:0]     s_axis_atvalid, s_axis_atready, s_axis_atlast;
  logic [NCH*BDW-1:0] s_axis_btdata;
  logic [NCH-1:0]     s_axis_btvalid, s_axis_btready;
  logic [ADW-1:0]     m_macc_atdata;
  logic               m_macc_atvalid, m_macc_atlast;
  logic [BDW-1:0]     m_macc_btdata;
  logic               m_macc_btvalid;
  logic               macc_rdy;
  logic [ODW-1:0]     s_macc_tdata;
  logic               s_macc_tvalid, s_macc_tready;
  logic [ODW-1:0]     m_axis_tdata;
  logic [IDW-1:0]     m_axis_tid;
  logic               m_axis_tvalid, m_axis_tready;

  macc_arbiter #(.NCH(NCH), .ADW(ADW), .BDW(BDW), .ODW(ODW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_atdata(s_axis_atdata), .s_axis_atvalid(s_axis_atvalid),
    .s_axis_atready(s_axis_atready), .s_axis_atlast(s_axis_atlast),
    .s_axis_btdata(s_axis_btdata), .s_axis_btvalid(s_axis_btvalid),
    .s_axis_btready(s_axis_btready),
    .m_macc_atdata(m_macc_atdata), .m_macc_atvalid(m_macc_atvalid),
    .m_macc_atready(macc_rdy), .m_macc_atlast(m_macc_atlast),
    .m_macc_btdata(m_macc_btdata), .m_macc_btvalid(m_macc_btvalid),
    .m_macc_btready(macc_rdy),
    .s_macc_tdata(s_macc_tdata), .s_macc_tvalid(s_macc_tvalid), .s_macc_tready(s_macc_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  // Per-channel beat storage: {last, A} and B, consumed by the channel drivers.
  logic [ADW:0]   a_mem [NCH][DEPTH];
  logic [BDW-1:0] b_mem [NCH][DEPTH];
  int a_wr [NCH], a_rd [NCH], b_wr [NCH], b_rd [NCH];

  bit a_hs [NCH];
  bit b_hs [NCH];
  bit ma_hs, mb_hs, r_hs, sm_hs, seen_rst;
  logic [ADW:0]          ma_cap, ta;
  logic [BDW-1:0]        mb_cap;
  logic signed [ADW-1:0] sa;
  logic signed [BDW-1:0] sb;
  logic [ADW:0]          ma_q [$];
  logic [BDW-1:0]        mb_q [$];
  logic [ODW-1:0]        res_q [$];
  longint                acc;
  longint                obs_d [$];
  int                    obs_id [$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int ch, input int a, input int b, input bit last);
    a_mem[ch][a_wr[ch]] = {last, ADW'(a)};
    a_wr[ch]++;
    b_mem[ch][b_wr[ch]] = BDW'(b);
    b_wr[ch]++;
  endtask

  task automatic wait_results(input string nm, input int n, input int budget);
    int cyc;
    cyc = 0;
    while (obs_d.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    if (obs_d.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got %0d results expected %0d", nm, obs_d.size(), n);
    end
  endtask

  task automatic chk_res(input string nm, input int idx, input longint exp_d, input int exp_id);
    if (idx < obs_d.size()) begin
      chk({nm, "_data"}, obs_d[idx], exp_d);
      chk({nm, "_tid"}, longint'(obs_id[idx]), longint'(exp_id));
    end else begin
      chk({nm, "_missing"}, -1, exp_d);
    end
  endtask

  // Channel drivers plus a behavioural Macc2: handshakes decided at negedge, applied after posedge.
  initial begin : engine
    acc = 0;
    s_axis_atdata = '0; s_axis_atvalid = '0; s_axis_atlast = '0;
    s_axis_btdata = '0; s_axis_btvalid = '0;
    s_macc_tdata = '0; s_macc_tvalid = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      a_wr[c] = 0; a_rd[c] = 0; b_wr[c] = 0; b_rd[c] = 0;
    end
    forever begin
      @(negedge clk);
      seen_rst = rst;
      for (int c = 0; c < NCH; c++) begin
        a_hs[c] = s_axis_atvalid[c] && s_axis_atready[c];
        b_hs[c] = s_axis_btvalid[c] && s_axis_btready[c];
      end
      ma_hs  = m_macc_atvalid && macc_rdy;
      ma_cap = {m_macc_atlast, m_macc_atdata};
      mb_hs  = m_macc_btvalid && macc_rdy;
      mb_cap = m_macc_btdata;
      sm_hs  = s_macc_tvalid && s_macc_tready;
      r_hs   = m_axis_tvalid && m_axis_tready;
      if (r_hs && !seen_rst) begin
        obs_d.push_back(longint'($signed(m_axis_tdata)));
        obs_id.push_back(int'(m_axis_tid));
      end
      @(posedge clk);
      #1;
      if (seen_rst) begin
        for (int c = 0; c < NCH; c++) begin
          a_rd[c] = a_wr[c];
          b_rd[c] = b_wr[c];
        end
        ma_q.delete(); mb_q.delete(); res_q.delete();
        acc = 0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (a_hs[c]) a_rd[c]++;
          if (b_hs[c]) b_rd[c]++;
        end
        if (ma_hs) ma_q.push_back(ma_cap);
        if (mb_hs) mb_q.push_back(mb_cap);
        if (sm_hs && res_q.size() > 0) void'(res_q.pop_front());
        while (ma_q.size() > 0 && mb_q.size() > 0) begin
          ta  = ma_q.pop_front();
          sa  = ta[ADW-1:0];
          sb  = mb_q.pop_front();
          acc = acc + longint'(sa) * longint'(sb);
          if (ta[ADW]) begin
            res_q.push_back(ODW'(acc));
            acc = 0;
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        s_axis_atvalid[c] = (a_rd[c] != a_wr[c]);
        s_axis_atdata[c*ADW +: ADW] = s_axis_atvalid[c] ? a_mem[c][a_rd[c]][ADW-1:0] : '0;
        s_axis_atlast[c]  = s_axis_atvalid[c] ? a_mem[c][a_rd[c]][ADW] : 1'b0;
        s_axis_btvalid[c] = (b_rd[c] != b_wr[c]);
        s_axis_btdata[c*BDW +: BDW] = s_axis_btvalid[c] ? b_mem[c][b_rd[c]] : '0;
      end
      s_macc_tvalid = (res_q.size() > 0);
      s_macc_tdata  = (res_q.size() > 0) ? res_q[0] : '0;
    end
  end

  typedef struct packed {
    int             ch;
    int             len;
    logic [3:0][15:0] a;
    logic [3:0][15:0] b;
    int             exp;
  } vec_t;

  function automatic vec_t mkvec(input int ch, input int len,
                                 input int a0, input int a1, input int a2, input int a3,
                                 input int b0, input int b1, input int b2, input int b3,
                                 input int exp);
    vec_t v;
    v.ch = ch; v.len = len; v.exp = exp;
    v.a[0] = 16'(a0); v.a[1] = 16'(a1); v.a[2] = 16'(a2); v.a[3] = 16'(a3);
    v.b[0] = 16'(b0); v.b[1] = 16'(b1); v.b[2] = 16'(b2); v.b[3] = 16'(b3);
    return v;
  endfunction

  vec_t vecs [6];
  logic [NCH-1:0] mask;
  int cyc, viol, base;

  initial begin : main
    vecs[0] = mkvec(2, 3,      1,      2,  3, 0,   4,   5,  6, 0,     32);
    vecs[1] = mkvec(0, 1,      7,      0,  0, 0,  -3,   0,  0, 0,    -21);
    vecs[2] = mkvec(1, 4,     -1,     -2,  3, 4,   5,   6, -7, 8,     -6);
    vecs[3] = mkvec(3, 2,    100,   -200,  0, 0, 300, 400,  0, 0, -50000);
    vecs[4] = mkvec(0, 2,  32767, -32768,  0, 0,   2,   2,  0, 0,     -2);
    vecs[5] = mkvec(3, 1,     -5,      0,  0, 0,  -5,   0,  0, 0,     25);

    rst = 1'b1;
    macc_rdy = 1'b1;
    m_axis_tready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_atready", longint'(s_axis_atready), 0);
    chk("rst_btready", longint'(s_axis_btready), 0);
    chk("rst_macc_avalid", longint'(m_macc_atvalid), 0);
    chk("rst_macc_bvalid", longint'(m_macc_btvalid), 0);
    chk("rst_axis_tvalid", longint'(m_axis_tvalid), 0);
    chk("rst_tag_count", longint'(dut.r_count), 0);

    // Single-channel frames from the table
    for (int i = 0; i < 6; i++) begin
      obs_d.delete(); obs_id.delete();
      viol = 0;
      mask = ~(NCH'(1) << vecs[i].ch);
      for (int k = 0; k < vecs[i].len; k++)
        push_beat(vecs[i].ch, int'($signed(vecs[i].a[k])), int'($signed(vecs[i].b[k])),
                  k == vecs[i].len - 1);
      tick();
      chk($sformatf("v%0d_idle_ready", i), longint'(s_axis_atready[vecs[i].ch]), 0);
      chk($sformatf("v%0d_idle_fwd", i), longint'(m_macc_atvalid), 0);
      tick();
      chk($sformatf("v%0d_grant", i), longint'(s_axis_atready[vecs[i].ch]), 1);
      cyc = 0;
      while (obs_d.size() < 1 && cyc < 40) begin
        if (((s_axis_atready | s_axis_btready) & mask) != '0) viol++;
        tick();
        cyc++;
      end
      chk_res($sformatf("v%0d", i), 0, longint'(vecs[i].exp), vecs[i].ch);
      chk($sformatf("v%0d_other_ready", i), viol, 0);
    end

    // All channels, two 2-beat frames each: strict rotation
    obs_d.delete(); obs_id.delete();
    for (int c = 0; c < NCH; c++)
      for (int f = 0; f < 2; f++) begin
        push_beat(c, c + 1, 3, 1'b0);
        push_beat(c, f + 2, c + 5, 1'b1);
      end
    wait_results("rr", 8, 200);
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < NCH; c++)
        chk_res($sformatf("rr_f%0d_c%0d", f, c), f*4 + c, longint'(3*(c+1) + (f+2)*(c+5)), c);

    // Tag FIFO full: fifth grant held until one pop
    obs_d.delete(); obs_id.delete();
    m_axis_tready = 1'b0;
    for (int c = 0; c < NCH; c++) push_beat(c, c + 10, 2, 1'b1);
    push_beat(0, -9, 9, 1'b1);
    repeat (30) tick();
    chk("full_ch0_pending", longint'(a_wr[0] - a_rd[0]), 1);
    chk("full_results_held", longint'(res_q.size()), 4);
    chk("full_tvalid", longint'(m_axis_tvalid), 1);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk("full_one_pop", longint'(obs_d.size()), 1);
    cyc = 0;
    while (a_wr[0] != a_rd[0] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("full_next_grant", longint'(a_wr[0] - a_rd[0]), 0);
    tick();
    chk("full_refilled", longint'(res_q.size()), 4);
    m_axis_tready = 1'b1;
    wait_results("full", 5, 50);
    for (int c = 0; c < NCH; c++)
      chk_res($sformatf("full_r%0d", c), c, longint'(2*(c+10)), c);
    chk_res("full_r4", 4, -81, 0);

    // Grant held across a stall while another channel waits
    obs_d.delete(); obs_id.delete();
    viol = 0;
    push_beat(1, 1, 2, 1'b0); push_beat(1, 1, 3, 1'b0);
    push_beat(1, 1, 4, 1'b0); push_beat(1, 1, 5, 1'b1);
    cyc = 0;
    while (!s_axis_atready[1] && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("hold_grant_ch1", longint'(s_axis_atready[1]), 1);
    macc_rdy = 1'b0;
    push_beat(3, 3, 5, 1'b0); push_beat(3, 4, 6, 1'b1);
    repeat (3) begin
      tick();
      if (s_axis_atready[3] || m_macc_atdata != ADW'(1)) viol++;
    end
    macc_rdy = 1'b1;
    cyc = 0;
    while (a_rd[1] != a_wr[1] && cyc < 20) begin
      if (s_axis_atready[3]) viol++;
      tick();
      cyc++;
    end
    wait_results("hold", 2, 40);
    chk("hold_ch3_blocked", viol, 0);
    chk_res("hold_r0", 0, 14, 1);
    chk_res("hold_r1", 1, 39, 3);

    // Reset mid-frame on ch0, after ch1 moved the pointer
    obs_d.delete(); obs_id.delete();
    push_beat(1, 2, 2, 1'b1);
    wait_results("prerst", 1, 20);
    base = a_rd[0];
    push_beat(0, 1, 1, 1'b0); push_beat(0, 2, 1, 1'b0);
    push_beat(0, 3, 1, 1'b0); push_beat(0, 4, 1, 1'b1);
    cyc = 0;
    while (a_rd[0] - base < 2 && cyc < 20) begin
      tick();
      cyc++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_atready", longint'(s_axis_atready), 0);
    chk("mrst_btready", longint'(s_axis_btready), 0);
    chk("mrst_macc_valid", longint'({m_macc_atvalid, m_macc_btvalid}), 0);
    chk("mrst_tvalid", longint'(m_axis_tvalid), 0);
    chk("mrst_tag_count", longint'(dut.r_count), 0);
    repeat (8) tick();
    chk("mrst_no_result", longint'(obs_d.size()), 1);
    obs_d.delete(); obs_id.delete();
    for (int c = 0; c < NCH; c++) push_beat(c, c + 1, c + 1, 1'b1);
    wait_results("mrst", 4, 60);
    for (int c = 0; c < NCH; c++)
      chk_res($sformatf("mrst_r%0d", c), c, longint'((c+1)*(c+1)), c);

    // Push and pop on the same edge at count 2
    obs_d.delete(); obs_id.delete();
    m_axis_tready = 1'b0;
    push_beat(0, 5, 5, 1'b1);
    push_beat(1, 6, 6, 1'b1);
    cyc = 0;
    while (res_q.size() < 2 && cyc < 30) begin
      tick();
      cyc++;
    end
    push_beat(2, 1, 1, 1'b0); push_beat(2, 2, 1, 1'b0); push_beat(2, 3, 1, 1'b1);
    cyc = 0;
    while (!(a_wr[2] - a_rd[2] == 1 && s_axis_atready[2] && s_axis_atvalid[2]) && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("pp_count_before", longint'(dut.r_count), 2);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    chk("pp_count_after", longint'(dut.r_count), 2);
    chk("pp_popped", longint'(obs_d.size()), 1);
    m_axis_tready = 1'b1;
    wait_results("pp", 3, 30);
    chk_res("pp_r0", 0, 25, 0);
    chk_res("pp_r1", 1, 36, 1);
    chk_res("pp_r2", 2, 6, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
